// File: rtl/led_step_controller.sv
// Button-driven LED pattern sequencer: sync, debounce and edge-detect two
// buttons, then step a 4-state pattern manually or on a divided tick.
module led_step_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_step,
    input  logic       btn_mode,
    output logic [3:0] led_out,
    output logic [1:0] state_out,
    output logic       auto_mode,
    output logic       step_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    // Bit 0 carries the step button, bit 1 the mode button.
    logic [1:0]    btn;
    logic [1:0]    s1_q;
    logic [1:0]    s2_q;
    logic [1:0]    db_q;
    logic [1:0]    db_prev_q;
    logic [1:0]    pulse_q;
    logic [DW-1:0] cnt_q [2];

    assign btn = {btn_mode, btn_step};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            pulse_q   <= '0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
        end else begin
            s1_q      <= btn;
            s2_q      <= s1_q;
            db_prev_q <= db_q;
            pulse_q   <= db_q & ~db_prev_q;
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_MAX) begin
                    db_q[i]  <= s2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    led_q;
    logic          auto_q;
    logic [TW-1:0] tick_q;
    logic          step_p;
    logic          mode_p;
    logic          tick;
    logic          advance;

    assign step_p  = pulse_q[0];
    assign mode_p  = pulse_q[1];
    assign tick    = auto_q && (tick_q == TICK_MAX);
    assign advance = step_p | tick;

    function automatic logic [3:0] decode(input state_t s);
        unique case (s)
            S0:      decode = 4'b0001;
            S1:      decode = 4'b0010;
            S2:      decode = 4'b0011;
            default: decode = 4'b0100;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = state_t'(state_q + 2'd1);
        end
    end

    // A step, a tick, or a mode change all restart the tick period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
            led_q   <= 4'b0001;
            auto_q  <= 1'b0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= decode(state_d);
            if (mode_p) begin
                auto_q <= ~auto_q;
            end
            if (mode_p || !auto_q || step_p || tick) begin
                tick_q <= '0;
            end else begin
                tick_q <= tick_q + 1'b1;
            end
        end
    end

    assign led_out    = led_q;
    assign state_out  = state_q;
    assign auto_mode  = auto_q;
    assign step_pulse = pulse_q[0];

endmodule

// File: tb/tb_led_step_controller.sv
// Scoreboard bench for led_step_controller with DEBOUNCE_CYCLES=4,
// TICK_DIV=8: expected state/mode changes are queued with their edge number.
module tb_led_step_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_step;
    logic       btn_mode;
    logic [3:0] led_out;
    logic [1:0] state_out;
    logic       auto_mode;
    logic       step_pulse;

    led_step_controller #(
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_step  (btn_step),
        .btn_mode  (btn_mode),
        .led_out   (led_out),
        .state_out (state_out),
        .auto_mode (auto_mode),
        .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       au;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_step = 0;
    bit   mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] led_of(input logic [1:0] s);
        logic [3:0] tbl [4];
        tbl[0] = 4'b0001;
        tbl[1] = 4'b0010;
        tbl[2] = 4'b0011;
        tbl[3] = 4'b0100;
        return tbl[s];
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, got, want, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int c, input logic [1:0] st, input logic au);
        exp_t e;
        e.cyc = c;
        e.st  = st;
        e.au  = au;
        sb.push_back(e);
    endtask

    // Monitor: every visible change of state/mode must match the queue head.
    initial begin : monitor
        logic [1:0] prev_st;
        logic       prev_au;
        exp_t       e;
        wait (mon_on);
        prev_st = state_out;
        prev_au = auto_mode;
        forever begin
            @(negedge clk);
            if (step_pulse === 1'b1) n_step++;
            chk("led_decode", {28'd0, led_out}, {28'd0, led_of(state_out)});
            if (state_out !== prev_st || auto_mode !== prev_au) begin
                if (sb.size() == 0) begin
                    chk("unexpected_change", {30'd0, state_out}, {30'd0, prev_st});
                end else begin
                    e = sb.pop_front();
                    chk("change_cycle", cyc, e.cyc);
                    chk("state_out", {30'd0, state_out}, {30'd0, e.st});
                    chk("auto_mode", {31'd0, auto_mode}, {31'd0, e.au});
                end
            end
            prev_st = state_out;
            prev_au = auto_mode;
        end
    end

    initial begin : stim
        int c;
        logic [1:0] seq [4];
        seq[0] = 2'd1;
        seq[1] = 2'd2;
        seq[2] = 2'd3;
        seq[3] = 2'd0;
        rst      = 1'b1;
        btn_step = 1'b0;
        btn_mode = 1'b0;
        idle(3);
        rst = 1'b0;
        chk("rst_led", {28'd0, led_out}, 32'h1);
        chk("rst_state", {30'd0, state_out}, 32'h0);
        chk("rst_auto", {31'd0, auto_mode}, 32'h0);
        chk("rst_pulse", {31'd0, step_pulse}, 32'h0);
        mon_on = 1'b1;

        // Glitch shorter than the debounce window.
        btn_step = 1'b1;
        idle(3);
        btn_step = 1'b0;
        idle(12);
        chk("glitch_state", {30'd0, state_out}, 32'h0);
        chk("glitch_pulses", n_step, 0);

        // Four manual presses, wrapping back to pattern 0.
        for (int i = 0; i < 4; i++) begin
            push(cyc + 8, seq[i], 1'b0);
            btn_step = 1'b1;
            idle(20);
            btn_step = 1'b0;
            idle(10);
        end
        chk("manual_pulses", n_step, 4);

        // AUTO with a step press landing on the tick at c+32.
        c = cyc;
        push(c + 8,  2'd0, 1'b1);
        push(c + 16, 2'd1, 1'b1);
        push(c + 24, 2'd2, 1'b1);
        push(c + 32, 2'd3, 1'b1);
        push(c + 40, 2'd0, 1'b1);
        push(c + 48, 2'd1, 1'b1);
        push(c + 56, 2'd2, 1'b1);
        push(c + 58, 2'd2, 1'b0);
        btn_mode = 1'b1;
        idle(20);
        btn_mode = 1'b0;
        idle(4);
        btn_step = 1'b1;
        idle(20);
        btn_step = 1'b0;
        idle(6);
        btn_mode = 1'b1;
        idle(20);
        btn_mode = 1'b0;
        idle(30);
        chk("frozen_state", {30'd0, state_out}, 32'h2);
        chk("auto_pulses", n_step, 5);

        // Reset mid-AUTO while a step debounce is in flight.
        c = cyc;
        push(c + 8,  2'd2, 1'b1);
        push(c + 16, 2'd3, 1'b1);
        push(c + 22, 2'd0, 1'b0);
        btn_mode = 1'b1;
        idle(10);
        btn_mode = 1'b0;
        idle(8);
        btn_step = 1'b1;
        idle(3);
        rst      = 1'b1;
        btn_step = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(25);

        chk("final_pulses", n_step, 5);
        chk("queue_drained", sb.size(), 0);
        chk("final_led", {28'd0, led_out}, 32'h1);
        chk("final_state", {30'd0, state_out}, 32'h0);
        chk("final_auto", {31'd0, auto_mode}, 32'h0);
        chk("final_pulse", {31'd0, step_pulse}, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
